lcd_si_receiver: RTL and testbench
==================================

Name: lcd_si_receiver

Overview:
- Responder end of the LCD serial interface (CS_n/SCL/SI/A0).
- Oversamples the bus with the system clock and assembles MSB-first bytes.
- Decodes the controller command set: start line, page, column high/low, display on/off, ADC, COM direction, bias, power control, regulator ratio, electronic volume (2-byte), internal reset.
- Issues display-RAM write strobes with page/column/data. Serves as a synthesizable display-RAM mirror front end and as the checker model for the LCD driver.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on cs_n/scl/si/a0 (≥2)
- NUM_COLUMNS, 132, column count; auto-increment saturates at NUM_COLUMNS-1
- NUM_PAGES, 9, valid pages 0..NUM_PAGES-1

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- cs_n  input  1  bus chip select, active low, asynchronous to clock
- scl  input  1  bus serial clock, asynchronous
- si  input  1  bus serial data, sampled on scl rising
- a0  input  1  bus data(1)/command(0) flag
- wr_en  output  1  one-clock pulse per data byte
- wr_page  output  4  page of the current write
- wr_col  output  8  column of the current write
- wr_data  output  8  data byte
- cmd_valid  output  1  one-clock pulse per decoded command byte
- cmd_byte  output  8  last command byte
- disp_on  output  1  display on/off state
- start_line  output  6  display start line
- volume  output  6  electronic volume
- adc_rev, com_rev, bias  output  1 each  ADC select, COM direction, bias select
- power_ctrl  output  3  power circuit bits
- reg_ratio  output  3  regulator ratio
- byte_error  output  1  one-clock pulse on an aborted byte

Behaviour:
- **Reset (reset_n low, async):**
  - All outputs 0.
  - Page = 0, column = 0.
  - Bit counter = 0.
  - FSM = CMD.
- **Sampling and latency:**
  - All bus inputs pass through SYNC_STAGES flops. A 1-flop delayed copy of synced scl gives rise detect.
  - On a detected rise with synced cs_n = 0: shift in synced si (MSB first), bit counter +1.
  - On the 8th bit, the byte and synced a0 (sampled on that same rise) are latched. Decode happens the next clock.
  - wr_en/cmd_valid rise exactly SYNC_STAGES+2 clocks after the raw 8th scl rising edge.
  - Bus requirement: scl high and low each ≥ SYNC_STAGES+1 clocks.
- **Framing:**
  - Synced cs_n = 1 clears the bit counter.
  - If cs_n rises with a counter of 1..7: pulse byte_error and discard the partial byte.
  - scl edges while cs_n = 1 are ignored.
- **FSM states:** CMD, VOL_ARG.
- **a0 = 1 (data byte, either state):**
  - wr_en pulse with wr_page = page, wr_col = column, wr_data = byte.
  - Then column +1 if column < NUM_COLUMNS-1, else hold (no wrap).
  - If received in VOL_ARG, return to CMD without updating volume.
- **a0 = 0 in CMD, decode priority top-down; cmd_valid pulses on each:**
  - 0xAE/0xAF: disp_on = bit0.
  - 0x40–0x7F: start_line = byte[5:0].
  - 0xB0–0xBF: page = byte[3:0] if < NUM_PAGES, else ignored (cmd_valid still pulses).
  - 0x10–0x1F: column[7:4] = byte[3:0].
  - 0x00–0x0F: column[3:0] = byte[3:0].
  - 0xA0/0xA1: adc_rev = bit0.
  - 0xC0–0xCF: com_rev = bit3.
  - 0xA2/0xA3: bias = bit0.
  - 0x28–0x2F: power_ctrl = byte[2:0].
  - 0x20–0x27: reg_ratio = byte[2:0].
  - 0x81: go to VOL_ARG.
  - 0xE2 (internal reset): page = 0, column = 0, start_line = 0; other registers kept.
  - Anything else: cmd_valid only.
- **a0 = 0 in VOL_ARG:**
  - volume = byte[5:0], cmd_valid pulses, return to CMD.
- **Column set:**
  - The high/low nibble writes are independent.
  - A column value ≥ NUM_COLUMNS is stored. A data write there still strobes, and the column does not increment.
- **Simultaneous events:**
  - The 8th-bit rise and cs_n rise in the same clock: the byte completes, with no byte_error.
  - Reset mid-byte discards the byte.

Decomposition:
- Shared package holds:
  - command opcodes/masks (CMD_DISP_ON 0xAF, CMD_DISP_OFF 0xAE, CMD_START_LINE 0x40, CMD_PAGE 0xB0, CMD_COL_HI 0x10, CMD_COL_LO 0x00, CMD_VOLUME 0x81, CMD_RESET 0xE2, CMD_ADC 0xA0, CMD_COM 0xC0, CMD_BIAS 0xA2, CMD_POWER 0x28, CMD_RATIO 0x20);
  - FSM state encodings.
  These are the same opcodes the LCD driver emits.
- One sub-module, lcd_si_deserializer: synchronizers, edge detect, bit counter, byte/a0 latch, byte_error. The top level holds the decode FSM and registers.

Test Plan:
- **Init sequence:** bytes 0xA2, 0xA0, 0xC8, 0x24, 0x81, 0x3F, 0x2F, 0xAF with a0 = 0 → bias = 0, adc_rev = 0, com_rev = 1, reg_ratio = 4, volume = 0x3F, power_ctrl = 7, disp_on = 1; 8 cmd_valid pulses, no wr_en.
- **Addressed write:** 0xB3, 0x12, 0x05 (a0 = 0), then 0xA5, 0x5A (a0 = 1) → wr_en at (page 3, col 0x25, 0xA5), then (3, 0x26, 0x5A); wr_en exactly SYNC_STAGES+2 clocks after each 8th scl rise.
- **Column saturation:** set column 131, write 3 data bytes → all three strobes at wr_col = 131.
- **Aborted byte:** 5 bits then cs_n high → byte_error pulse, no wr_en/cmd_valid; the next full byte 0xAE decodes correctly (disp_on = 0).
- **Internal reset:** page 5, col 40, start_line 0x40|17, then 0xE2 → page = 0, column = 0, start_line = 0, disp_on/volume unchanged.
- **Volume interrupted:** 0x81, then data 0x11 (a0 = 1) → wr_en with 0x11, volume unchanged, FSM back to CMD. Then assert reset_n low mid-byte → all outputs 0 immediately (async).

Source files
------------

// File: rtl/lcd_si_receiver_pkg.sv
// Shared definitions for the LCD serial-interface responder.
// Holds the controller opcodes and their match masks, the decode FSM state
// encoding and a small opcode-match helper. The LCD driver emits these
// same opcodes.
package lcd_si_receiver_pkg;

  localparam logic [7:0] CMD_DISP_OFF   = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON    = 8'hAF;
  localparam logic [7:0] CMD_START_LINE = 8'h40;
  localparam logic [7:0] CMD_PAGE       = 8'hB0;
  localparam logic [7:0] CMD_COL_HI     = 8'h10;
  localparam logic [7:0] CMD_COL_LO     = 8'h00;
  localparam logic [7:0] CMD_ADC        = 8'hA0;
  localparam logic [7:0] CMD_COM        = 8'hC0;
  localparam logic [7:0] CMD_BIAS       = 8'hA2;
  localparam logic [7:0] CMD_POWER      = 8'h28;
  localparam logic [7:0] CMD_RATIO      = 8'h20;
  localparam logic [7:0] CMD_VOLUME     = 8'h81;
  localparam logic [7:0] CMD_RESET      = 8'hE2;

  localparam logic [7:0] MASK_DISP  = 8'hFE;
  localparam logic [7:0] MASK_START = 8'hC0;
  localparam logic [7:0] MASK_PAGE  = 8'hF0;
  localparam logic [7:0] MASK_COL   = 8'hF0;
  localparam logic [7:0] MASK_ADC   = 8'hFE;
  localparam logic [7:0] MASK_COM   = 8'hF0;
  localparam logic [7:0] MASK_BIAS  = 8'hFE;
  localparam logic [7:0] MASK_POWER = 8'hF8;
  localparam logic [7:0] MASK_RATIO = 8'hF8;

  typedef enum logic {
    ST_CMD     = 1'b0,
    ST_VOL_ARG = 1'b1
  } rx_state_t;

  function automatic logic op_match(input logic [7:0] b,
                                    input logic [7:0] op,
                                    input logic [7:0] mask);
    return (b & mask) == op;
  endfunction

endpackage

// File: rtl/lcd_si_receiver_if.sv
// LCD serial bus: cs_n (active-low select), scl (serial clock),
// si (serial data, valid on scl rise), a0 (1 = data, 0 = command).
// master: the LCD driver side; slave: the responder side.
interface lcd_si_receiver_if;
  logic cs_n;
  logic scl;
  logic si;
  logic a0;

  modport master (output cs_n, output scl, output si, output a0);
  modport slave  (input  cs_n, input  scl, input  si, input  a0);
endinterface

// File: rtl/lcd_si_deserializer.sv
// Bus front end: synchronizes cs_n/scl/si/a0 into the clock domain,
// detects scl rises, shifts bytes in MSB first and latches byte + a0.
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   cs_n, scl, si, a0   raw asynchronous bus inputs
//   byte_valid          one-clock pulse when a byte completes
//   byte_data, byte_a0  completed byte and its a0 flag (held)
//   byte_error          one-clock pulse when a partial byte is aborted
module lcd_si_deserializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       scl,
  input  logic       si,
  input  logic       a0,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_a0,
  output logic       byte_error
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] si_sync;
  logic [SYNC_STAGES-1:0] a0_sync;
  logic                   scl_d;
  logic                   cs_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;

  logic cs_s, scl_s, si_s, a0_s;
  logic rise, cs_rose, complete;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign si_s  = si_sync[SYNC_STAGES-1];
  assign a0_s  = a0_sync[SYNC_STAGES-1];

  assign rise    = scl_s & ~scl_d;
  assign cs_rose = cs_s & ~cs_d;
  // An 8th-bit rise that lands in the same clock as the deselect still
  // completes the byte instead of being treated as an abort.
  assign complete = rise && (bit_cnt == 3'd7) && (!cs_s || cs_rose);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync  <= {SYNC_STAGES{1'b1}};
      scl_sync <= '0;
      si_sync  <= '0;
      a0_sync  <= '0;
      scl_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], si};
      a0_sync  <= {a0_sync[SYNC_STAGES-2:0], a0};
      scl_d    <= scl_s;
      cs_d     <= cs_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_a0    <= 1'b0;
      byte_error <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_error <= 1'b0;
      if (complete) begin
        byte_valid <= 1'b1;
        byte_data  <= {shift, si_s};
        byte_a0    <= a0_s;
        bit_cnt    <= 3'd0;
      end else if (cs_s) begin
        if (bit_cnt != 3'd0) byte_error <= 1'b1;
        bit_cnt <= 3'd0;
      end else if (rise) begin
        shift   <= {shift[5:0], si_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_si_receiver.sv
// Responder end of the LCD serial interface. Decodes the controller
// command set and issues display-RAM write strobes.
// Ports:
//   clock, reset_n   system clock, async active-low reset
//   bus              serial bus (slave modport)
//   wr_en/page/col/data   one-clock write strobe with address and data
//   cmd_valid, cmd_byte   one-clock pulse per command byte, last command
//   disp_on, start_line, volume, adc_rev, com_rev, bias,
//   power_ctrl, reg_ratio configuration state
//   byte_error            pulse on an aborted partial byte
//
// state      | meaning
// ST_CMD     | next a0=0 byte is decoded as a command
// ST_VOL_ARG | next a0=0 byte is the electronic volume argument
module lcd_si_receiver
  import lcd_si_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_COLUMNS = 132,
  parameter int NUM_PAGES   = 9
) (
  input  logic                clock,
  input  logic                reset_n,
  lcd_si_receiver_if.slave    bus,
  output logic                wr_en,
  output logic [3:0]          wr_page,
  output logic [7:0]          wr_col,
  output logic [7:0]          wr_data,
  output logic                cmd_valid,
  output logic [7:0]          cmd_byte,
  output logic                disp_on,
  output logic [5:0]          start_line,
  output logic [5:0]          volume,
  output logic                adc_rev,
  output logic                com_rev,
  output logic                bias,
  output logic [2:0]          power_ctrl,
  output logic [2:0]          reg_ratio,
  output logic                byte_error
);

  localparam logic [7:0] LAST_COL = 8'(NUM_COLUMNS - 1);
  localparam logic [4:0] PAGE_LIM = 5'(NUM_PAGES);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_a0;

  lcd_si_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clock      (clock),
    .reset_n    (reset_n),
    .cs_n       (bus.cs_n),
    .scl        (bus.scl),
    .si         (bus.si),
    .a0         (bus.a0),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_a0    (byte_a0),
    .byte_error (byte_error)
  );

  rx_state_t  state, state_nxt;
  logic [3:0] page;
  logic [7:0] column;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_CMD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_valid) begin
      if (byte_a0 || state == ST_VOL_ARG) state_nxt = ST_CMD;
      else if (byte_data == CMD_VOLUME)   state_nxt = ST_VOL_ARG;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_page    <= 4'd0;
      wr_col     <= 8'd0;
      wr_data    <= 8'd0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'd0;
      disp_on    <= 1'b0;
      start_line <= 6'd0;
      volume     <= 6'd0;
      adc_rev    <= 1'b0;
      com_rev    <= 1'b0;
      bias       <= 1'b0;
      power_ctrl <= 3'd0;
      reg_ratio  <= 3'd0;
      page       <= 4'd0;
      column     <= 8'd0;
    end else begin
      wr_en     <= 1'b0;
      cmd_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_a0) begin
          wr_en   <= 1'b1;
          wr_page <= page;
          wr_col  <= column;
          wr_data <= byte_data;
          // Saturate at the last column; an out-of-range column also holds.
          if (column < LAST_COL) column <= column + 8'd1;
        end else begin
          cmd_valid <= 1'b1;
          cmd_byte  <= byte_data;
          if (state == ST_VOL_ARG) begin
            volume <= byte_data[5:0];
          end else if (op_match(byte_data, CMD_DISP_OFF, MASK_DISP)) begin
            disp_on <= (byte_data == CMD_DISP_ON);
          end else if (op_match(byte_data, CMD_START_LINE, MASK_START)) begin
            start_line <= byte_data[5:0];
          end else if (op_match(byte_data, CMD_PAGE, MASK_PAGE)) begin
            if ({1'b0, byte_data[3:0]} < PAGE_LIM) page <= byte_data[3:0];
          end else if (op_match(byte_data, CMD_COL_HI, MASK_COL)) begin
            column[7:4] <= byte_data[3:0];
          end else if (op_match(byte_data, CMD_COL_LO, MASK_COL)) begin
            column[3:0] <= byte_data[3:0];
          end else if (op_match(byte_data, CMD_ADC, MASK_ADC)) begin
            adc_rev <= byte_data[0];
          end else if (op_match(byte_data, CMD_COM, MASK_COM)) begin
            com_rev <= byte_data[3];
          end else if (op_match(byte_data, CMD_BIAS, MASK_BIAS)) begin
            bias <= byte_data[0];
          end else if (op_match(byte_data, CMD_POWER, MASK_POWER)) begin
            power_ctrl <= byte_data[2:0];
          end else if (op_match(byte_data, CMD_RATIO, MASK_RATIO)) begin
            reg_ratio <= byte_data[2:0];
          end else if (byte_data == CMD_RESET) begin
            page       <= 4'd0;
            column     <= 8'd0;
            start_line <= 6'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_si_receiver.sv
module tb_lcd_si_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int HOLD        = SYNC_STAGES + 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  lcd_si_receiver_if bus();

  logic       wr_en, cmd_valid, disp_on, adc_rev, com_rev, bias, byte_error;
  logic [3:0] wr_page;
  logic [7:0] wr_col, wr_data, cmd_byte;
  logic [5:0] start_line, volume;
  logic [2:0] power_ctrl, reg_ratio;

  lcd_si_receiver #(.SYNC_STAGES(SYNC_STAGES), .NUM_COLUMNS(132), .NUM_PAGES(9)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .wr_en(wr_en), .wr_page(wr_page), .wr_col(wr_col), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .disp_on(disp_on),
    .start_line(start_line), .volume(volume), .adc_rev(adc_rev),
    .com_rev(com_rev), .bias(bias), .power_ctrl(power_ctrl),
    .reg_ratio(reg_ratio), .byte_error(byte_error)
  );

  typedef struct {
    logic [7:0] b;
    logic       a0;
    logic [3:0] pg;
    logic [7:0] col;
    logic       disp;
    logic [5:0] sl;
    logic [5:0] vol;
    logic       adc;
    logic       com;
    logic       bs;
    logic [2:0] pwr;
    logic [2:0] rat;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0, cmd_cnt = 0, err_cnt = 0;
  logic [3:0] l_page = '0;
  logic [7:0] l_col = '0, l_data = '0;

  always @(negedge clock) begin
    if (wr_en) begin
      wr_cnt <= wr_cnt + 1;
      l_page <= wr_page;
      l_col  <= wr_col;
      l_data <= wr_data;
    end
    if (cmd_valid)  cmd_cnt <= cmd_cnt + 1;
    if (byte_error) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [52:0] all_out();
    return {wr_en, wr_page, wr_col, wr_data, cmd_valid, cmd_byte, disp_on,
            start_line, volume, adc_rev, com_rev, bias, power_ctrl,
            reg_ratio, byte_error};
  endfunction

  function automatic logic [21:0] regs_now();
    return {disp_on, start_line, volume, adc_rev, com_rev, bias, power_ctrl, reg_ratio};
  endfunction

  // One bit: scl low for HOLD clocks with si set, then scl high for HOLD clocks.
  // On the last bit of a checked byte the strobe must appear exactly
  // SYNC_STAGES+2 clock edges after the raw rise.
  task automatic send_bit(input logic bitv, input logic last, input logic chk_lat,
                          input logic exp_wr);
    @(negedge clock);
    bus.si  = bitv;
    bus.scl = 1'b0;
    repeat (HOLD) @(posedge clock);
    @(negedge clock);
    bus.scl = 1'b1;
    if (last && chk_lat) begin
      repeat (SYNC_STAGES + 1) @(posedge clock);
      #1;
      chk("latency_early", 64'({wr_en, cmd_valid}), 64'(2'b00));
      @(posedge clock);
      #1;
      chk("latency_edge", 64'({wr_en, cmd_valid}), exp_wr ? 64'(2'b10) : 64'(2'b01));
    end else begin
      repeat (HOLD) @(posedge clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a0v, input logic chk_lat);
    bus.a0 = a0v;
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0, chk_lat, a0v);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, w0, e0;
    logic [7:0] b;

    tbl[0]  = '{8'hA2,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h00,1'b0,1'b0,1'b0,3'd0,3'd0};
    tbl[1]  = '{8'hA0,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h00,1'b0,1'b0,1'b0,3'd0,3'd0};
    tbl[2]  = '{8'hC8,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h00,1'b0,1'b1,1'b0,3'd0,3'd0};
    tbl[3]  = '{8'h24,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h00,1'b0,1'b1,1'b0,3'd0,3'd4};
    tbl[4]  = '{8'h81,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h00,1'b0,1'b1,1'b0,3'd0,3'd4};
    tbl[5]  = '{8'h3F,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd0,3'd4};
    tbl[6]  = '{8'h2F,1'b0,4'h0,8'h00,1'b0,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[7]  = '{8'hAF,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[8]  = '{8'hB3,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[9]  = '{8'h12,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[10] = '{8'h05,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[11] = '{8'hA5,1'b1,4'h3,8'h25,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[12] = '{8'h5A,1'b1,4'h3,8'h26,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[13] = '{8'h18,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[14] = '{8'h03,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[15] = '{8'h01,1'b1,4'h3,8'h83,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[16] = '{8'h02,1'b1,4'h3,8'h83,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[17] = '{8'h03,1'b1,4'h3,8'h83,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[18] = '{8'h0F,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[19] = '{8'h44,1'b1,4'h3,8'h8F,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[20] = '{8'hBA,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[21] = '{8'h55,1'b1,4'h3,8'h8F,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b0,3'd7,3'd4};
    tbl[22] = '{8'hA3,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[23] = '{8'hB5,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[24] = '{8'h12,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[25] = '{8'h08,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[26] = '{8'h51,1'b0,4'h0,8'h00,1'b1,6'd17,6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[27] = '{8'hE2,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[28] = '{8'h77,1'b1,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[29] = '{8'h81,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[30] = '{8'h11,1'b1,4'h0,8'h01,1'b1,6'd0, 6'h3F,1'b0,1'b1,1'b1,3'd7,3'd4};
    tbl[31] = '{8'hA1,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b1,1'b1,1'b1,3'd7,3'd4};
    tbl[32] = '{8'h81,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h3F,1'b1,1'b1,1'b1,3'd7,3'd4};
    tbl[33] = '{8'h2A,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h2A,1'b1,1'b1,1'b1,3'd7,3'd4};
    tbl[34] = '{8'hC0,1'b0,4'h0,8'h00,1'b1,6'd0, 6'h2A,1'b1,1'b0,1'b1,3'd7,3'd4};

    bus.cs_n = 1'b1;
    bus.scl  = 1'b0;
    bus.si   = 1'b0;
    bus.a0   = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 64'(all_out()), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.cs_n = 1'b0;
    repeat (HOLD) @(posedge clock);

    for (int i = 0; i < NV; i++) begin
      c0 = cmd_cnt;
      w0 = wr_cnt;
      send_byte(tbl[i].b, tbl[i].a0, 1'b1);
      @(negedge clock);
      #1;
      chk($sformatf("v%0d_strobes", i), 64'({8'(wr_cnt - w0), 8'(cmd_cnt - c0)}),
          tbl[i].a0 ? 64'(16'h0100) : 64'(16'h0001));
      if (tbl[i].a0)
        chk($sformatf("v%0d_write", i), 64'({l_page, l_col, l_data}),
            64'({tbl[i].pg, tbl[i].col, tbl[i].b}));
      else
        chk($sformatf("v%0d_cmd_byte", i), 64'(cmd_byte), 64'(tbl[i].b));
      chk($sformatf("v%0d_regs", i), 64'(regs_now()),
          64'({tbl[i].disp, tbl[i].sl, tbl[i].vol, tbl[i].adc, tbl[i].com,
               tbl[i].bs, tbl[i].pwr, tbl[i].rat}));
    end
    chk("table_no_byte_error", 64'(err_cnt), 64'd0);

    // Aborted byte: 5 bits then deselect.
    c0 = cmd_cnt; w0 = wr_cnt; e0 = err_cnt;
    bus.a0 = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    bus.scl = 1'b0;
    repeat (HOLD) @(posedge clock);
    @(negedge clock);
    bus.cs_n = 1'b1;
    repeat (8) @(posedge clock);
    @(negedge clock);
    #1;
    chk("abort_byte_error", 64'(err_cnt - e0), 64'd1);
    chk("abort_no_strobe", 64'({8'(wr_cnt - w0), 8'(cmd_cnt - c0)}), 64'd0);
    @(negedge clock);
    bus.cs_n = 1'b0;
    repeat (HOLD) @(posedge clock);
    send_byte(8'hAE, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    chk("abort_next_disp_on", 64'(disp_on), 64'd0);
    chk("abort_next_cmd_cnt", 64'(cmd_cnt - c0), 64'd1);
    chk("abort_next_cmd_byte", 64'(cmd_byte), 64'hAE);

    // 8th rise and deselect in the same clock: byte completes, no error.
    c0 = cmd_cnt; e0 = err_cnt;
    b = 8'hAF;
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    bus.si  = b[0];
    bus.scl = 1'b0;
    repeat (HOLD) @(posedge clock);
    @(negedge clock);
    bus.scl  = 1'b1;
    bus.cs_n = 1'b1;
    repeat (HOLD + 2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("same_clk_disp_on", 64'(disp_on), 64'd1);
    chk("same_clk_cmd_cnt", 64'(cmd_cnt - c0), 64'd1);
    chk("same_clk_no_error", 64'(err_cnt - e0), 64'd0);

    // scl activity while deselected must be ignored.
    c0 = cmd_cnt;
    send_byte(8'hA0, 1'b0, 1'b0);
    repeat (HOLD) @(posedge clock);
    @(negedge clock);
    #1;
    chk("deselected_ignored", 64'({adc_rev, 8'(cmd_cnt - c0)}), 64'(9'h100));
    @(negedge clock);
    bus.cs_n = 1'b0;
    repeat (HOLD) @(posedge clock);
    send_byte(8'hA0, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    chk("reselect_adc", 64'({adc_rev, 8'(cmd_cnt - c0)}), 64'(9'h001));

    // Column continues from 2 on page 0 after the table.
    send_byte(8'h99, 1'b1, 1'b1);
    @(negedge clock);
    #1;
    chk("post_write", 64'({l_page, l_col, l_data}), 64'({4'h0, 8'h02, 8'h99}));

    // Asynchronous reset in the middle of a byte.
    bus.a0 = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(all_out()), 64'd0);
    @(negedge clock);
    bus.scl = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_release_outputs", 64'(all_out()), 64'd0);
    c0 = cmd_cnt;
    send_byte(8'hAF, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    chk("after_reset_byte", 64'({disp_on, cmd_byte, 8'(cmd_cnt - c0)}),
        64'({1'b1, 8'hAF, 8'h01}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
